jtframe_led_blink: RTL

//  Output stage after the frame-stretched system LED logic. It drives the physical LED pin.

---
 rtl/jtframe_led_pkg.sv | 27 ++
 rtl/jtframe_led_pwm.sv | 79 +++++++
 rtl/jtframe_led_blink.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jtframe_led_pkg.sv
// jtframe_led_pkg: shared definitions for the LED output stage.
//   - JTFRAME_FS(lvbl, lvbl_d): frame-strobe expression. It is true on the
//     first clock where LVBL is low after being high. Other frame-timed
//     jtframe blocks use it too.
//   - PASS/ON/OFF/GAP: state encoding of the blink-code sequencer.
//   - FCNT_W: width of the frame counter.
`ifndef JTFRAME_FS
`define JTFRAME_FS(lvbl, lvbl_d) (!(lvbl) && (lvbl_d))
`endif

package jtframe_led_pkg;

   localparam logic [1:0] PASS = 2'd0;
   localparam logic [1:0] ON   = 2'd1;
   localparam logic [1:0] OFF  = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   localparam int FCNT_W = 8;

   typedef enum logic [1:0] {
      ST_PASS = PASS,
      ST_ON   = ON,
      ST_OFF  = OFF,
      ST_GAP  = GAP
   } led_state_e;

endpackage

// File: rtl/jtframe_led_pwm.sv
// jtframe_led_pwm: PWM dimmer for the pass-through LED path.
// The macro JTFRAME_LED_BREATH_EN changes the duty source. When it is
// defined, an internal triangle ramp sets the duty: it steps once per frame
// strobe and restarts from 0 whenever en is low. When it is undefined,
// duty_in is used directly.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   fs          one-cycle frame strobe (used only by the breath ramp)
//   duty_in     static duty; 0 = off, all-ones = fully on
//   en          PWM output enable (pass-through state with LED requested)
//   pwm_on      combinational PWM level, already gated by en
module jtframe_led_pwm #(
   parameter int PWMW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fs,
   input  logic [PWMW-1:0] duty_in,
   input  logic            en,
   output logic            pwm_on
);

   logic [PWMW-1:0] cnt_q;
   logic [PWMW-1:0] duty;

   // Free-running counter. A brightness change applies on the next clock,
   // with no sync to the PWM period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_q + 1'b1;
   end

`ifdef JTFRAME_LED_BREATH_EN
   logic [PWMW-1:0] ramp_q;
   logic            down_q;
   logic            unused_duty;

   assign unused_duty = ^duty_in;

   // Triangle ramp: it climbs to all-ones, then steps back down to 0 and
   // repeats. It is held at 0 while the LED is not lit in pass-through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramp_q <= '0;
         down_q <= 1'b0;
      end else if (!en) begin
         ramp_q <= '0;
         down_q <= 1'b0;
      end else if (fs) begin
         if (!down_q) begin
            if (ramp_q == '1) begin
               down_q <= 1'b1;
               ramp_q <= ramp_q - 1'b1;
            end else begin
               ramp_q <= ramp_q + 1'b1;
            end
         end else begin
            if (ramp_q == '0) begin
               down_q <= 1'b0;
               ramp_q <= ramp_q + 1'b1;
            end else begin
               ramp_q <= ramp_q - 1'b1;
            end
         end
      end
   end

   assign duty = ramp_q;
`else
   logic unused_fs;

   assign unused_fs = fs;
   assign duty      = duty_in;
`endif

   // A strict compare would never reach 100 % duty, so all-ones is special-cased.
   assign pwm_on = en & ((duty == '1) | (cnt_q < duty));

endmodule

// File: rtl/jtframe_led_blink.sv
// jtframe_led_blink: physical LED driver.
// It normally passes led_in through a PWM dimmer. On request it plays a
// blink code: N long flashes, then a dark gap. All durations are counted in
// video frames. A frame starts on the falling edge of LVBL.
// Optional feature macro: JTFRAME_LED_BREATH_EN (breathing duty in
// pass-through, implemented in jtframe_led_pwm).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   LVBL        vertical blank, active low
//   led_in      upstream LED request
//   brightness  pass-through PWM duty
//   code        number of flashes (0 = no-op)
//   code_vld    code request valid
//   code_rdy    block can accept a code
//   busy        code sequence in progress
//   led_out     registered pin drive, XOR POL
//   state_o     sequencer state, for debug
module jtframe_led_blink
   import jtframe_led_pkg::*;
#(
   parameter int PWMW  = 4,
   parameter int ON_F  = 8,
   parameter int OFF_F = 8,
   parameter int GAP_F = 48,
   parameter bit POL   = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            LVBL,
   input  logic            led_in,
   input  logic [PWMW-1:0] brightness,
   input  logic [3:0]      code,
   input  logic            code_vld,
   output logic            code_rdy,
   output logic            busy,
   output logic            led_out,
   output logic [1:0]      state_o
);

   localparam logic [FCNT_W-1:0] ON_LAST  = FCNT_W'(ON_F - 1);
   localparam logic [FCNT_W-1:0] OFF_LAST = FCNT_W'(OFF_F - 1);
   localparam logic [FCNT_W-1:0] GAP_LAST = FCNT_W'(GAP_F - 1);

   led_state_e        state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [3:0]        rem_q, rem_d;
   logic              rdy_q, rdy_d;
   logic              led_q, led_d;
   logic              lvbl_q, fs_q;
   logic              pwm_on, pwm_en, accept;

   // Registered frame strobe: a one-cycle pulse after each LVBL falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvbl_q <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         lvbl_q <= LVBL;
         fs_q   <= `JTFRAME_FS(LVBL, lvbl_q);
      end
   end

   assign pwm_en = (state_q == ST_PASS) & led_in;

   jtframe_led_pwm #(.PWMW(PWMW)) u_pwm (
      .clk     (clk),
      .rst_n   (rst_n),
      .fs      (fs_q),
      .duty_in (brightness),
      .en      (pwm_en),
      .pwm_on  (pwm_on)
   );

   // Handshake: a code transfers on the clock edge where code_vld and
   // code_rdy are both high. code_rdy is high only in PASS. It drops on the
   // same edge that accepts a non-zero code, so a requester that keeps
   // code_vld high cannot start a second transfer. Outside PASS, code_vld
   // is ignored and nothing is queued.
   assign accept = code_vld & rdy_q & (state_q == ST_PASS);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      rem_d   = rem_q;
      led_d   = 1'b0;
      case (state_q)
         ST_PASS: begin
            led_d = led_in & pwm_on;
            if (accept && code != 4'd0) begin
               rem_d   = code;
               fcnt_d  = '0;
               state_d = ST_ON;
            end
         end
         ST_ON: begin
            led_d = 1'b1;
            if (fs_q) begin
               if (fcnt_q == ON_LAST) begin
                  fcnt_d  = '0;
                  // rem is at least 1 here, so this cannot underflow.
                  rem_d   = rem_q - 4'd1;
                  state_d = ST_OFF;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         ST_OFF: begin
            if (fs_q) begin
               if (fcnt_q == OFF_LAST) begin
                  fcnt_d  = '0;
                  state_d = (rem_q != 4'd0) ? ST_ON : ST_GAP;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (fs_q) begin
               if (fcnt_q == GAP_LAST) begin
                  fcnt_d  = '0;
                  state_d = ST_PASS;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_PASS;
      endcase
      // Ready only while PASS is kept across this edge. On return from GAP,
      // ready rises one cycle after the state reaches PASS.
      rdy_d = (state_q == ST_PASS) && (state_d == ST_PASS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PASS;
         fcnt_q  <= '0;
         rem_q   <= '0;
         rdy_q   <= 1'b0;
         led_q   <= POL;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         rem_q   <= rem_d;
         rdy_q   <= rdy_d;
         led_q   <= led_d ^ POL;
      end
   end

   assign code_rdy = rdy_q;
   assign busy     = (state_q != ST_PASS);
   assign led_out  = led_q;
   assign state_o  = state_q;

endmodule
